// File: rtl/router_hdr_rewrite_pkg.sv
// Shared constants and types for the egress header-rewrite stage:
// header bit offsets in the first beat, one-hot NF/CPU queue codes and FSM state.
package router_hdr_rewrite_pkg;

    // Field LSBs inside the 256-bit first beat (Ethernet + IPv4, big-endian from bit 255)
    localparam int DMAC_LSB  = 208;
    localparam int SMAC_LSB  = 160;
    localparam int TTL_LSB   = 72;
    localparam int CKSUM_LSB = 48;

    localparam logic [7:0] NF0  = 8'h01;
    localparam logic [7:0] NF1  = 8'h04;
    localparam logic [7:0] NF2  = 8'h10;
    localparam logic [7:0] NF3  = 8'h40;
    localparam logic [7:0] CPU0 = 8'h02;
    localparam logic [7:0] CPU1 = 8'h08;
    localparam logic [7:0] CPU2 = 8'h20;
    localparam logic [7:0] CPU3 = 8'h80;

    localparam logic [7:0] NF_MASK  = NF0 | NF1 | NF2 | NF3;
    localparam logic [7:0] CPU_MASK = CPU0 | CPU1 | CPU2 | CPU3;

    typedef enum logic { S_HEAD, S_BODY } state_t;

    typedef enum logic [1:0] { C_PASS, C_FWD, C_MISS, C_TTL } class_t;

endpackage

// File: rtl/ip_cksum_ttl_dec.sv
// Combinational TTL decrement with the matching incremental IPv4 checksum fix:
// HC' = HC + 0x0100 in one's-complement arithmetic (end-around carry folded back in).
module ip_cksum_ttl_dec (
    input  logic [7:0]  ttl,
    input  logic [15:0] cksum,
    output logic [7:0]  ttl_dec,
    output logic [15:0] cksum_new
);

    logic [16:0] sum;

    assign sum       = {1'b0, cksum} + 17'h00100;
    assign ttl_dec   = ttl - 8'd1;
    // A carry out can only occur when sum[15:0] <= 0x00FF, so folding it cannot overflow again.
    assign cksum_new = sum[15:0] + {15'd0, sum[16]};

endmodule

// File: rtl/router_hdr_rewrite.sv
// Egress header-rewrite stage: classifies each packet on its first beat using the ARP
// lookup result, rewrites MACs/TTL/checksum on forward, or steers to the CPU queue.
module router_hdr_rewrite
    import router_hdr_rewrite_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_TUSER_WIDTH = 128,
    parameter int SRC_PORT_POS  = 16,
    parameter int DST_PORT_POS  = 24
) (
    input  logic                       AXI_ACLK,
    input  logic                       AXI_RESET,

    input  logic [C_DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [C_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
    input  logic [C_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                       S_AXIS_TVALID,
    input  logic                       S_AXIS_TLAST,
    output logic                       S_AXIS_TREADY,

    output logic [C_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
    output logic [C_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                       M_AXIS_TVALID,
    output logic                       M_AXIS_TLAST,
    input  logic                       M_AXIS_TREADY,

    input  logic                       lookup_valid,
    input  logic                       arp_hit,
    input  logic [47:0]                dest_mac,
    input  logic [7:0]                 oq_in,
    input  logic [47:0]                mac0,
    input  logic [47:0]                mac1,
    input  logic [47:0]                mac2,
    input  logic [47:0]                mac3,

    output logic [31:0]                forwarded_count,
    output logic [31:0]                arp_miss_count,
    output logic [31:0]                ttl_expired_count
);

    state_t                     state;
    class_t                     cls;
    logic                       accept;
    logic                       head_accept;
    logic                       oq_ok;
    logic [47:0]                port_mac;
    logic [7:0]                 src_port;
    logic [7:0]                 cpu_dst;
    logic [7:0]                 ttl_dec;
    logic [15:0]                cksum_new;
    logic [C_DATA_WIDTH-1:0]    head_data;
    logic [C_TUSER_WIDTH-1:0]   head_user;

    assign S_AXIS_TREADY = (!M_AXIS_TVALID || M_AXIS_TREADY) && (state == S_BODY || lookup_valid);
    assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
    assign head_accept   = accept && (state == S_HEAD);

    assign src_port = S_AXIS_TUSER[SRC_PORT_POS +: 8];
    assign cpu_dst  = (src_port << 1) & CPU_MASK;

    ip_cksum_ttl_dec u_cksum (
        .ttl       (S_AXIS_TDATA[TTL_LSB +: 8]),
        .cksum     (S_AXIS_TDATA[CKSUM_LSB +: 16]),
        .ttl_dec   (ttl_dec),
        .cksum_new (cksum_new)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        oq_ok     = 1'b1;
        port_mac  = 48'd0;
        cls       = C_PASS;
        head_data = S_AXIS_TDATA;
        head_user = S_AXIS_TUSER;

        case (oq_in)
            NF0:     port_mac = mac0;
            NF1:     port_mac = mac1;
            NF2:     port_mac = mac2;
            NF3:     port_mac = mac3;
            default: oq_ok    = 1'b0;
        endcase

        // CPU-originated packets (no NF source bit) bypass classification entirely.
        if ((src_port & NF_MASK) == 8'd0)
            cls = C_PASS;
        else if (!arp_hit || !oq_ok)
            cls = C_MISS;
        else if (S_AXIS_TDATA[TTL_LSB +: 8] <= 8'd1)
            cls = C_TTL;
        else
            cls = C_FWD;

        case (cls)
            C_FWD: begin
                head_data[DMAC_LSB +: 48]  = dest_mac;
                head_data[SMAC_LSB +: 48]  = port_mac;
                head_data[TTL_LSB +: 8]    = ttl_dec;
                head_data[CKSUM_LSB +: 16] = cksum_new;
                head_user[DST_PORT_POS +: 8] = oq_in;
            end
            C_MISS, C_TTL: head_user[DST_PORT_POS +: 8] = cpu_dst;
            default: ;
        endcase
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            state             <= S_HEAD;
            M_AXIS_TVALID     <= 1'b0;
            M_AXIS_TDATA      <= '0;
            M_AXIS_TSTRB      <= '0;
            M_AXIS_TUSER      <= '0;
            M_AXIS_TLAST      <= 1'b0;
            forwarded_count   <= 32'd0;
            arp_miss_count    <= 32'd0;
            ttl_expired_count <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            if (accept) begin
                M_AXIS_TVALID <= 1'b1;
                M_AXIS_TDATA  <= (state == S_HEAD) ? head_data : S_AXIS_TDATA;
                M_AXIS_TUSER  <= (state == S_HEAD) ? head_user : S_AXIS_TUSER;
                M_AXIS_TSTRB  <= S_AXIS_TSTRB;
                M_AXIS_TLAST  <= S_AXIS_TLAST;
                state         <= S_AXIS_TLAST ? S_HEAD : S_BODY;
            end else if (M_AXIS_TREADY) begin
                M_AXIS_TVALID <= 1'b0;
            end

            if (head_accept) begin
                case (cls)
                    C_FWD:   forwarded_count   <= forwarded_count + 32'd1;
                    C_MISS:  arp_miss_count    <= arp_miss_count + 32'd1;
                    C_TTL:   ttl_expired_count <= ttl_expired_count + 32'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_router_hdr_rewrite.sv
// Scoreboard bench for router_hdr_rewrite: driver pushes reference-model beats at input
// acceptance, an independent monitor pops and compares every output handshake.
module tb_router_hdr_rewrite;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  strb;
        logic [127:0] user;
        logic         last;
    } beat_t;

    logic         AXI_ACLK;
    logic         AXI_RESET;
    logic [255:0] S_AXIS_TDATA;
    logic [31:0]  S_AXIS_TSTRB;
    logic [127:0] S_AXIS_TUSER;
    logic         S_AXIS_TVALID;
    logic         S_AXIS_TLAST;
    logic         S_AXIS_TREADY;
    logic [255:0] M_AXIS_TDATA;
    logic [31:0]  M_AXIS_TSTRB;
    logic [127:0] M_AXIS_TUSER;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TLAST;
    logic         M_AXIS_TREADY;
    logic         lookup_valid;
    logic         arp_hit;
    logic [47:0]  dest_mac;
    logic [7:0]   oq_in;
    logic [47:0]  macs [4];
    logic [31:0]  forwarded_count;
    logic [31:0]  arp_miss_count;
    logic [31:0]  ttl_expired_count;

    int          vectors = 0;
    int          miscompares = 0;
    beat_t       exp_q[$];
    int          pat_q[$];
    int unsigned mdl_fwd = 0;
    int unsigned mdl_miss = 0;
    int unsigned mdl_ttl = 0;

    router_hdr_rewrite dut (
        .AXI_ACLK          (AXI_ACLK),
        .AXI_RESET         (AXI_RESET),
        .S_AXIS_TDATA      (S_AXIS_TDATA),
        .S_AXIS_TSTRB      (S_AXIS_TSTRB),
        .S_AXIS_TUSER      (S_AXIS_TUSER),
        .S_AXIS_TVALID     (S_AXIS_TVALID),
        .S_AXIS_TLAST      (S_AXIS_TLAST),
        .S_AXIS_TREADY     (S_AXIS_TREADY),
        .M_AXIS_TDATA      (M_AXIS_TDATA),
        .M_AXIS_TSTRB      (M_AXIS_TSTRB),
        .M_AXIS_TUSER      (M_AXIS_TUSER),
        .M_AXIS_TVALID     (M_AXIS_TVALID),
        .M_AXIS_TLAST      (M_AXIS_TLAST),
        .M_AXIS_TREADY     (M_AXIS_TREADY),
        .lookup_valid      (lookup_valid),
        .arp_hit           (arp_hit),
        .dest_mac          (dest_mac),
        .oq_in             (oq_in),
        .mac0              (macs[0]),
        .mac1              (macs[1]),
        .mac2              (macs[2]),
        .mac3              (macs[3]),
        .forwarded_count   (forwarded_count),
        .arp_miss_count    (arp_miss_count),
        .ttl_expired_count (ttl_expired_count)
    );

    initial AXI_ACLK = 1'b0;
    always #5 AXI_ACLK = ~AXI_ACLK;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Reference model: 0 pass, 1 forward, 2 miss, 3 TTL expired.
    function automatic beat_t model_head(input beat_t in, input logic hit, input logic [47:0] dmac,
                                         input logic [7:0] oq, output int kind);
        beat_t       o;
        logic [7:0]  src;
        logic [7:0]  ttl;
        int unsigned ck;
        int          q;
        o   = in;
        src = in.user[23:16];
        ttl = in.data[79:72];
        q   = -1;
        for (int i = 0; i < 4; i++) if (oq == (8'h01 << (2 * i))) q = i;
        if ((src & 8'h55) == 8'h00) begin
            kind = 0;
        end else if (!hit || q < 0) begin
            kind = 2;
            o.user[31:24] = {src[6:0], 1'b0};
        end else if (ttl <= 8'd1) begin
            kind = 3;
            o.user[31:24] = {src[6:0], 1'b0};
        end else begin
            kind = 1;
            o.data[255:208] = dmac;
            o.data[207:160] = macs[q];
            o.data[79:72]   = ttl - 8'd1;
            ck = int'(in.data[63:48]) + 256;
            if (ck > 65535) ck = ck - 65535;
            o.data[63:48]   = ck[15:0];
            o.user[31:24]   = oq;
        end
        return o;
    endfunction

    function automatic logic [255:0] mk_hdr(input logic [7:0] ttl, input logic [15:0] ck);
        logic [255:0] h;
        h = rnd256();
        h[79:72] = ttl;
        h[63:48] = ck;
        return h;
    endfunction

    function automatic logic [127:0] mk_user(input logic [7:0] src);
        logic [127:0] u;
        u = rnd128();
        u[23:16] = src;
        return u;
    endfunction

    // Downstream ready: scripted pattern when queued, otherwise random ~75% ready.
    initial begin
        M_AXIS_TREADY = 1'b0;
        forever begin
            @(posedge AXI_ACLK);
            #1;
            if (pat_q.size() > 0) M_AXIS_TREADY = pat_q.pop_front() != 0;
            else                  M_AXIS_TREADY = $urandom_range(0, 3) != 0;
        end
    end

    // Monitor: compares each output handshake against the scoreboard and checks hold stability.
    initial begin
        beat_t        cur;
        beat_t        e;
        logic [417:0] held_v;
        bit           held;
        held = 0;
        forever begin
            @(negedge AXI_ACLK);
            cur = {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST};
            if (AXI_RESET) begin
                held = 0;
            end else begin
                if (held) check("hold_stable", {M_AXIS_TVALID, cur}, held_v);
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_beat: got %h expected none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_beat", cur, e);
                    end
                    held = 0;
                end else if (M_AXIS_TVALID) begin
                    held   = 1;
                    held_v = {1'b1, cur};
                end else begin
                    held = 0;
                end
            end
        end
    end

    task automatic send_pkt(input int nbeats, input int nsend, input logic [255:0] hdata,
                            input logic [127:0] huser, input logic hit, input logic [47:0] dmac,
                            input logic [7:0] oq, input int lv_delay);
        beat_t in;
        beat_t e;
        int    waited;
        int    kind;
        bit    done;
        for (int b = 0; b < nsend; b++) begin
            in.data = (b == 0) ? hdata : rnd256();
            in.user = (b == 0) ? huser : rnd128();
            in.strb = $urandom();
            in.last = (b == nbeats - 1);
            S_AXIS_TDATA  = in.data;
            S_AXIS_TUSER  = in.user;
            S_AXIS_TSTRB  = in.strb;
            S_AXIS_TLAST  = in.last;
            S_AXIS_TVALID = 1'b1;
            waited = 0;
            done   = 0;
            while (!done) begin
                if (b == 0) begin
                    lookup_valid = (waited >= lv_delay);
                    arp_hit      = hit;
                    dest_mac     = dmac;
                    oq_in        = oq;
                end else begin
                    lookup_valid = $urandom_range(0, 1) != 0;
                    arp_hit      = $urandom_range(0, 1) != 0;
                    dest_mac     = {$urandom(), 16'h0};
                    oq_in        = $urandom();
                end
                @(negedge AXI_ACLK);
                if (b == 0 && !lookup_valid) check("ready_gated", {511'd0, S_AXIS_TREADY}, 512'd0);
                if (S_AXIS_TREADY) begin
                    if (b == 0) begin
                        e = model_head(in, hit, dmac, oq, kind);
                        case (kind)
                            1: mdl_fwd++;
                            2: mdl_miss++;
                            3: mdl_ttl++;
                            default: ;
                        endcase
                    end else begin
                        e = in;
                    end
                    exp_q.push_back(e);
                    done = 1;
                end
                @(posedge AXI_ACLK);
                #1;
                waited++;
                if (!done && waited > 500) begin
                    $display("FAIL accept_timeout: got no accept expected accept within 500 cycles");
                    $fatal(1, "input stalled");
                end
            end
        end
        S_AXIS_TVALID = 1'b0;
        lookup_valid  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(posedge AXI_ACLK);
            n++;
        end
        #1;
        check("drain", {480'd0, exp_q.size()}, 512'd0);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_fwd"},  {480'd0, forwarded_count},   {480'd0, mdl_fwd});
        check({tag, "_miss"}, {480'd0, arp_miss_count},    {480'd0, mdl_miss});
        check({tag, "_ttl"},  {480'd0, ttl_expired_count}, {480'd0, mdl_ttl});
    endtask

    initial begin
        logic [7:0]  src;
        logic [7:0]  oq;
        logic [7:0]  ttl;
        logic        hit;
        logic [47:0] dm;
        AXI_RESET     = 1'b1;
        S_AXIS_TDATA  = '0;
        S_AXIS_TSTRB  = '0;
        S_AXIS_TUSER  = '0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        lookup_valid  = 1'b0;
        arp_hit       = 1'b0;
        dest_mac      = '0;
        oq_in         = '0;
        macs[0] = 48'h02_00_00_00_00_00;
        macs[1] = 48'h02_00_00_00_00_01;
        macs[2] = 48'h02_00_00_00_00_02;
        macs[3] = 48'h02_00_00_00_00_03;

        repeat (3) @(posedge AXI_ACLK);
        #1;
        check("reset_out", {M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST}, 512'd0);
        check_counters("reset");
        AXI_RESET = 1'b0;
        @(posedge AXI_ACLK);
        #1;

        // Directed: forward, checksum wrap, miss, TTL expiry.
        send_pkt(1, 1, mk_hdr(8'h40, 16'hB1E6), mk_user(8'h01), 1'b1, 48'hAA_BB_CC_DD_EE_FF, 8'h04, 0);
        drain();
        check_counters("hit");
        send_pkt(2, 2, mk_hdr(8'h05, 16'hFF7F), mk_user(8'h04), 1'b1, 48'h11_22_33_44_55_66, 8'h10, 1);
        send_pkt(1, 1, mk_hdr(8'h40, 16'h1234), mk_user(8'h10), 1'b0, 48'h0, 8'h01, 0);
        send_pkt(2, 2, mk_hdr(8'h01, 16'h4321), mk_user(8'h01), 1'b1, 48'h0A_0B_0C_0D_0E_0F, 8'h04, 0);
        drain();
        check_counters("directed");

        // 3-beat packet with stalls downstream and a delayed lookup result.
        pat_q = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 1};
        send_pkt(3, 3, mk_hdr(8'h22, 16'h8000), mk_user(8'h40), 1'b1, 48'hDE_AD_BE_EF_00_01, 8'h40, 3);
        drain();

        // Randomized traffic.
        for (int p = 0; p < 40; p++) begin
            case ($urandom_range(0, 9))
                0:       src = 8'h02;
                1:       src = 8'h00;
                default: src = 8'h01 << (2 * $urandom_range(0, 3));
            endcase
            oq  = ($urandom_range(0, 6) != 0) ? (8'h01 << (2 * $urandom_range(0, 3))) : 8'($urandom());
            hit = $urandom_range(0, 9) < 7;
            case ($urandom_range(0, 4))
                0:       ttl = 8'h00;
                1:       ttl = 8'h01;
                2:       ttl = 8'h02;
                default: ttl = $urandom();
            endcase
            dm = {$urandom(), 16'($urandom())};
            send_pkt($urandom_range(1, 3), 0, 256'd0, 128'd0, 1'b0, 48'd0, 8'd0, 0);
            begin
                int nb;
                nb = $urandom_range(1, 3);
                send_pkt(nb, nb, mk_hdr(ttl, 16'($urandom())), mk_user(src), hit, dm, oq, $urandom_range(0, 2));
            end
        end
        drain();
        check_counters("random");

        // Reset asserted while beat 2 of a 4-beat packet is held in the output register.
        pat_q = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        send_pkt(4, 2, mk_hdr(8'h30, 16'h0101), mk_user(8'h04), 1'b1, 48'h12_34_56_78_9A_BC, 8'h01, 0);
        AXI_RESET = 1'b1;
        #1;
        exp_q.delete();
        mdl_fwd  = 0;
        mdl_miss = 0;
        mdl_ttl  = 0;
        check("reset_valid", {511'd0, M_AXIS_TVALID}, 512'd0);
        check_counters("midreset");
        @(posedge AXI_ACLK);
        #3;
        AXI_RESET = 1'b0;
        @(posedge AXI_ACLK);
        #1;
        send_pkt(2, 2, mk_hdr(8'h09, 16'hFEFF), mk_user(8'h10), 1'b1, 48'h66_55_44_33_22_11, 8'h10, 0);
        drain();
        check_counters("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/router_hdr_rewrite.md
# router_hdr_rewrite

Egress header-rewrite stage of the router output-port-lookup pipeline. It sits directly after the ARP lookup stage and consumes that stage's per-packet result: `arp_hit`, next-hop `dest_mac`, and one-hot output queue. On a hit it rewrites the Ethernet header, decrements TTL with an incremental checksum fix, and sets the TUSER destination port. Misses and TTL-expired packets are sent to the CPU queue paired with the source port.

## Interface
- `C_DATA_WIDTH`, 256, AXIS data width (first beat holds Ethernet + IPv4 header, big-endian from bit 255).
- `C_TUSER_WIDTH`, 128, AXIS TUSER width.
- `SRC_PORT_POS`, 16, LSB of the 8-bit one-hot source-port field in TUSER.
- `DST_PORT_POS`, 24, LSB of the 8-bit one-hot destination-port field in TUSER.
- `AXI_ACLK` in 1: single clock.
- `AXI_RESET` in 1: asynchronous, active-high reset.
- `S_AXIS_TDATA` in `C_DATA_WIDTH`, `S_AXIS_TSTRB` in `C_DATA_WIDTH/8`, `S_AXIS_TUSER` in `C_TUSER_WIDTH`, `S_AXIS_TVALID` in 1, `S_AXIS_TLAST` in 1, `S_AXIS_TREADY` out 1: input stream.
- `M_AXIS_TDATA`, `M_AXIS_TSTRB`, `M_AXIS_TUSER`, `M_AXIS_TVALID`, `M_AXIS_TLAST` out; `M_AXIS_TREADY` in: output stream, same widths.
- `lookup_valid` in 1: ARP result for the packet at the stream head is valid.
- `arp_hit` in 1: next hop resolved.
- `dest_mac` in 48: next-hop MAC.
- `oq_in` in 8: one-hot NF output queue (bit 0, 2, 4 or 6).
- `mac0`, `mac1`, `mac2`, `mac3` in 48 each: router port MACs for queues 0/2/4/6.
- `forwarded_count`, `arp_miss_count`, `ttl_expired_count` out 32 each: statistics.

## Operation
- FSM states:
  - `S_HEAD`: waiting for the first beat.
  - `S_BODY`: passing the remaining beats.
- Transitions:
  - First beat is accepted only when `S_AXIS_TVALID && lookup_valid && S_AXIS_TREADY`.
  - After accepting the first beat, go to `S_BODY` unless `TLAST` is set.
  - In `S_BODY`, an accepted beat with `TLAST` returns to `S_HEAD`.
- Forward condition: `arp_hit`, `oq_in` is exactly one of {0x01, 0x04, 0x10, 0x40}, and TTL (bits 79:72) > 1.
- Forward rewrite, first beat only:
  - bits 255:208 = `dest_mac`.
  - bits 207:160 = MAC of the port selected by `oq_in`.
  - TTL = TTL−1.
  - Checksum (bits 63:48) = HC + 16'h0100, with end-around carry (RFC 1624), computed in 17 bits with the carry folded in.
  - TUSER dst field = `oq_in`.
  - `forwarded_count` +1.
- Miss or invalid oq: data is unchanged; TUSER dst = (src one-hot) << 1, the CPU queue; `arp_miss_count` +1.
- Hit with TTL ≤ 1: data is unchanged; dst = CPU queue as above; `ttl_expired_count` +1.
- Source field with no NF bit (0,2,4,6) set, i.e. the packet came from the CPU: pass through unchanged; no counter changes.
- Beats in `S_BODY` pass through unchanged.
- All counters wrap at 2^32 without saturating.

## Timing
- Output is a single registered stage; latency is 1 cycle from input acceptance to `M_AXIS_TVALID`.
- `S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY`. In `S_HEAD` it is additionally gated by `lookup_valid`.
- Throughput is 1 beat/cycle when downstream is ready; there are no bubbles between packets.
- Output must stay stable while `M_AXIS_TVALID && !M_AXIS_TREADY`.
- Side-band inputs are sampled only on the first-beat acceptance cycle; later changes have no effect on that packet.
- Reset values: FSM = `S_HEAD`; `M_AXIS_TVALID` = 0; `M_AXIS_TDATA`/`TSTRB`/`TUSER`/`TLAST` = 0; all counters = 0.
- Reset asserted mid-packet: any held beat is discarded and the FSM returns to `S_HEAD`. The upstream FIFO is reset by the same signal.
- Counter increments occur on the first-beat acceptance edge. When several packets are classified in consecutive cycles, each increments exactly once.

## Structure
- Shared package:
  - header bit-offset constants: DMAC, SMAC, TTL, CKSUM.
  - one-hot queue constants: NF0–NF3, CPU0–CPU3.
  - FSM state enum.
- One sub-module, `ip_cksum_ttl_dec`: combinational TTL decrement plus incremental checksum. Verified standalone.

## Test plan
- Hit, `oq_in`=0x04, TTL=0x40, cksum=0xB1E6, mac1=02:00:00:00:00:01 → TTL 0x3F, cksum 0xB2E6, SMAC=mac1, DMAC=`dest_mac`, TUSER dst=0x04, `forwarded_count`=1.
- Checksum wrap: TTL=0x05, cksum=0xFF7F → cksum 0x0080 (end-around carry).
- Miss, src=0x10 → dst=0x20, data bit-identical, `arp_miss_count`=1.
- Hit with TTL=0x01, src=0x01 → dst=0x02, `ttl_expired_count`=1, TTL unchanged.
- 3-beat packet with `M_AXIS_TREADY` toggling 1,0,0,1 and `lookup_valid` delayed 3 cycles → no beat lost or duplicated, output held stable, only beat 0 modified.
- Reset asserted on beat 2 of 4 → `M_AXIS_TVALID`=0 immediately; next packet is rewritten correctly from `S_HEAD`; counters are 0.
